// File: rtl/sram_uart_pkg.sv
// Shared definitions for the UART SRAM link: command-byte layout, frame
// length and the host-side state encoding. The SRAM controller's frame
// decoder imports the same package so both ends agree on the wire format.
package sram_uart_pkg;

   // Opcode carried in the command byte
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // Command byte: {op, 2'b00, addr[4:0]}
   localparam int unsigned CMD_OP_BIT   = 7;
   localparam int unsigned CMD_ADDR_MSB = 4;
   localparam int unsigned CMD_ADDR_LSB = 0;
   localparam int unsigned ADDR_W       = 5;

   // Payload bytes following a write command / returned for a read
   localparam int unsigned FRAME_DATA_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DATA,
      WAIT,
      DONE
   } state_e;

   // Build the command byte for a request
   function automatic logic [7:0] cmd_byte(input logic we, input logic [ADDR_W-1:0] addr);
      logic [7:0] b;
      b = '0;
      b[CMD_OP_BIT] = we ? OP_WRITE : OP_READ;
      b[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
      return b;
   endfunction

   // Select byte idx of a 32-bit word, idx 0 = least significant
   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      b = '0;
      case (idx)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sram_uart_host.sv
// Host-side initiator for the UART SRAM link. Converts word read/write
// requests into command frames on the TX byte stream and reassembles the
// 4-byte read response from the RX byte stream, abandoning a read if the
// responder goes quiet for TIMEOUT_CYCLES cycles.
module sram_uart_host
   import sram_uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [7:0]  rx_data
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
   // The counter is compared one step early so that DONE lands exactly
   // TIMEOUT_CYCLES+1 cycles after the last clearing point.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       LAST_BYTE = 2'(FRAME_DATA_BYTES - 1);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [4:0]        addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              tmo_flag_q, tmo_flag_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) state_d = CMD;
         CMD:  if (tx_ready) state_d = we_q ? DATA : WAIT;
         DATA: if (tx_ready && cnt_q == LAST_BYTE) state_d = DONE;
         WAIT: begin
            // A received byte takes priority over an expiring timeout
            if (rx_valid) begin
               if (cnt_q == LAST_BYTE) state_d = DONE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from current state and latched request
   always_comb begin
      req_ready   = (state_q == IDLE);
      rx_ready    = (state_q == IDLE) || (state_q == WAIT);
      tx_valid    = (state_q == CMD) || (state_q == DATA);
      rsp_valid   = (state_q == DONE);
      rsp_rdata   = (state_q == DONE) ? rdata_q : '0;
      rsp_timeout = (state_q == DONE) && tmo_flag_q;
      tx_data     = '0;
      if (state_q == CMD)       tx_data = cmd_byte(we_q, addr_q);
      else if (state_q == DATA) tx_data = word_byte(wdata_q, cnt_q);
   end

   // Datapath next-state: request latch, byte/timeout counters, rdata assembly
   always_comb begin
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      rdata_d    = rdata_q;
      tmo_flag_d = tmo_flag_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               cnt_d      = '0;
               tmo_d      = '0;
               rdata_d    = '0;
               tmo_flag_d = 1'b0;
            end
         end
         CMD: begin
            if (tx_ready) begin
               cnt_d = '0;
               tmo_d = '0;
            end
         end
         DATA: begin
            if (tx_ready) cnt_d = cnt_q + 2'd1;
         end
         WAIT: begin
            if (rx_valid) begin
               case (cnt_q)
                  2'd0: rdata_d[7:0]   = rx_data;
                  2'd1: rdata_d[15:8]  = rx_data;
                  2'd2: rdata_d[23:16] = rx_data;
                  default: rdata_d[31:24] = rx_data;
               endcase
               cnt_d = cnt_q + 2'd1;
               tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
               tmo_flag_d = 1'b1;
               rdata_d    = '0;
               tmo_d      = TMO_MAX;
            end else if (tmo_q != TMO_MAX) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         rdata_q    <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         rdata_q    <= rdata_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

endmodule

// File: tb/tb_sram_uart_host.sv
// Scoreboard bench for sram_uart_host: stimulus pushes expected TX bytes and
// responses into queues, a negedge monitor pops and compares them.
module tb_sram_uart_host;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  rx_data;

   sram_uart_host #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [7:0] data; int at;} txe_t;
   typedef struct {logic [31:0] rdata; logic to; int at;} rspe_t;
   txe_t  txq[$];
   rspe_t rspq[$];

   int n_tests = 0;
   int n_fail  = 0;
   int txr_mode = 0;   // 0: tx_ready held 1, 1: random
   bit prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // tx_ready driver
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = (txr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compare every TX transfer and response pulse against the queues
   initial begin : mon
      txe_t  te;
      rspe_t re;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
               check("tx_hold_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (tx_valid && tx_ready) begin
               if (txq.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL tx_unexpected: got %h expected none", tx_data);
               end else begin
                  te = txq.pop_front();
                  check("tx_byte", {24'b0, tx_data}, {24'b0, te.data});
                  if (te.at >= 0) check("tx_cycle", cyc, te.at);
               end
            end
            if (rsp_valid) begin
               if (rspq.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL rsp_unexpected: got %h expected none", rsp_rdata);
               end else begin
                  re = rspq.pop_front();
                  check("rsp_rdata", rsp_rdata, re.rdata);
                  check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, re.to});
                  if (re.at >= 0) check("rsp_cycle", cyc, re.at);
               end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   // Issue a request; returns the acceptance cycle, leaves caller 1ns after the next posedge
   task automatic do_req(input logic we, input logic [4:0] a, input logic [31:0] wd, output int acc);
      req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (acc < 0) begin
         n_tests++; n_fail++;
         $display("FAIL req_accept: got no acceptance expected acceptance");
      end
   endtask

   // Present one RX byte until consumed; returns the consumption cycle
   task automatic send_rx(input logic [7:0] b, output int at);
      rx_data = b; rx_valid = 1'b1;
      at = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rx_ready) begin
            at = cyc;
            break;
         end
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
      if (at < 0) begin
         n_tests++; n_fail++;
         $display("FAIL rx_consume: got no consumption expected consumption");
      end
   endtask

   task automatic write_op(input logic [7:0] cmd, input logic [4:0] a, input logic [31:0] wd, input bit timed);
      int acc;
      do_req(1'b1, a, wd, acc);
      txq.push_back('{cmd, timed ? acc + 1 : -1});
      for (int i = 0; i < 4; i++) txq.push_back('{wd[8*i +: 8], timed ? acc + 2 + i : -1});
      rspq.push_back('{32'h0, 1'b0, timed ? acc + 6 : -1});
   endtask

   task automatic read_op(input logic [7:0] cmd, input logic [4:0] a, input logic [31:0] rbytes,
                          input int nbytes, input logic [31:0] exp_rdata, input logic exp_to);
      int acc, m;
      do_req(1'b0, a, 32'h0, acc);
      txq.push_back('{cmd, acc + 1});
      m = -1;
      for (int i = 0; i < nbytes; i++) send_rx(rbytes[8*i +: 8], m);
      rspq.push_back('{exp_rdata, exp_to, exp_to ? m + int'(TMO) + 1 : m + 1});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (txq.size() == 0 && rspq.size() == 0) break;
      end
      check({name, "_tx_drained"}, txq.size(), 0);
      check({name, "_rsp_drained"}, rspq.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      @(negedge clk);
      check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
      check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
      check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_timeout"}, {31'b0, rsp_timeout}, 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int acc;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_vals("reset");
      @(posedge clk); #1;

      // Write with tx_ready held high: exact cycle timing
      write_op(8'h8A, 5'h0A, 32'hDEADBEEF, 1'b1);
      wait_drain("write");

      // Read returning 78 56 34 12
      read_op(8'h1F, 5'h1F, 32'h12345678, 4, 32'h12345678, 1'b0);
      wait_drain("read");

      // Write with tx_ready randomly stalled
      txr_mode = 1;
      write_op(8'h83, 5'h03, 32'hCAFEF00D, 1'b0);
      wait_drain("stall_write");
      txr_mode = 0;
      @(posedge clk); #1;

      // Read with only two response bytes: timeout
      read_op(8'h02, 5'h02, 32'h0000BBAA, 2, 32'h0, 1'b1);
      wait_drain("timeout");

      // Stray byte in IDLE, then a read returning 01 02 03 04
      rx_data = 8'h55; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      @(posedge clk); #1;
      read_op(8'h11, 5'h11, 32'h04030201, 4, 32'h04030201, 1'b0);
      wait_drain("stray");

      // Reset after two data bytes of a write
      do_req(1'b1, 5'h07, 32'h11223344, acc);
      txq.push_back('{8'h87, acc + 1});
      txq.push_back('{8'h44, acc + 2});
      txq.push_back('{8'h33, acc + 3});
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      txq.delete();
      rspq.delete();
      @(posedge clk); #1 reset = 1'b0;
      check_reset_vals("midreset");
      repeat (8) begin
         @(posedge clk); #1;
      end
      write_op(8'h87, 5'h07, 32'h11223344, 1'b1);
      wait_drain("after_reset");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_uart_host.md
# sram_uart_host

Host-side initiator for the UART SRAM link. It turns word-level read/write requests into the byte command frames that the on-chip SRAM controller decodes. For reads it reassembles the 4-byte response. It sits between a host request source and a byte-level UART transmitter/receiver pair, for example in an FPGA test harness or a bench model of the Tiny Tapeout pin side.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65536 — idle cycles allowed between response bytes before a read is abandoned; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  5  SRAM word address
- req_wdata  in  32  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: read response was not completed
- tx_valid  out  1  byte offered to the UART transmitter
- tx_ready  in  1  transmitter accepts the byte
- tx_data  out  8  byte to transmit
- rx_valid  in  1  byte received from the UART receiver
- rx_ready  out  1  block consumes the received byte
- rx_data  in  8  received byte

## Operation
Frame format (fixed link protocol):
- Command byte: {op, 2'b00, addr[4:0]}, with op = 1 for write and op = 0 for read.
- Write frame: command byte, then wdata in 4 bytes, LSB first (wdata[7:0] first). The link sends no acknowledge.
- Read frame: command byte only. The responder returns 4 bytes, LSB first.

Handshakes:
- TX byte transfers when tx_valid && tx_ready. tx_data is stable while tx_valid is high and not yet accepted.
- RX byte is consumed when rx_valid && rx_ready.
- Request is accepted when req_valid && req_ready. we, addr and wdata are latched on acceptance.

State machine:
- IDLE: req_ready = 1, rx_ready = 1. RX bytes arriving here are stray and are discarded. On request acceptance, go to CMD.
- CMD: tx_valid = 1 with the command byte. On transfer, a write goes to DATA with byte counter = 0; a read goes to WAIT with byte counter = 0 and the timeout counter cleared.
- DATA: tx_valid = 1 with wdata byte[cnt]. On transfer, cnt++. After the transfer with cnt = 3, go to DONE.
- WAIT: rx_ready = 1. Each consumed byte is shifted into rdata position cnt, cnt++, and the timeout counter is cleared. After the byte with cnt = 3, go to DONE. If the timeout counter reaches TIMEOUT_CYCLES, set the timeout flag, clear rdata and go to DONE.
- DONE: rsp_valid = 1 for exactly one cycle with rsp_rdata and rsp_timeout, then go to IDLE.

Outputs outside these states:
- tx_valid = 0 outside CMD/DATA.
- rx_ready = 0 in CMD, DATA and DONE.
- rsp_valid = 0 outside DONE.

Counter widths:
- Byte counter is 2 bits.
- Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it cannot wrap.

## Timing
- Reset values: req_ready = 1, tx_valid = 0, tx_data = 0, rx_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0. State = IDLE, counters = 0.
- Reset mid-frame: the frame is abandoned with no rsp_valid. The following request starts a fresh command byte.
- Request accepted in cycle N: tx_valid is high in cycle N+1.
- Write with tx_ready held at 1: transfers happen in N+1 to N+5, and rsp_valid pulses in N+6.
- Read with the final rx byte consumed in cycle M: rsp_valid pulses in M+1.
- Timeout: rsp_valid pulses TIMEOUT_CYCLES+1 cycles after the last cleared point, with no rx byte in between.
- A new request is never accepted in the DONE cycle. The earliest next acceptance is the cycle after the rsp_valid pulse.
- rx_valid and the timeout reached in the same WAIT cycle: the byte wins and the counter clears.

## Structure
- Package sram_uart_pkg holds:
  - OP_READ/OP_WRITE constants;
  - the command-byte field positions;
  - FRAME_DATA_BYTES = 4;
  - the state enum {IDLE, CMD, DATA, WAIT, DONE}.
- The SRAM controller's frame decoder shares this package.
- No sub-module. The byte counter, timeout counter and rdata shift register are inline.

## Test plan
- Write, addr 5'h0A, wdata 32'hDEADBEEF, tx_ready = 1: tx bytes 8'h8A, EF, BE, AD, DE in consecutive cycles; rsp_valid one cycle later with rdata 0 and timeout 0.
- Read, addr 5'h1F, responder returns 78, 56, 34, 12: tx byte 8'h1F; rsp_rdata = 32'h12345678, rsp_timeout = 0.
- tx_ready toggled 0/1 randomly during a write: bytes are identical and in order, tx_data is stable while stalled, and exactly one rsp_valid pulse occurs.
- Read with TIMEOUT_CYCLES = 16 and only 2 response bytes: rsp_valid with rsp_timeout = 1 and rdata = 0, 17 cycles after the second byte.
- Stray rx byte 8'h55 while IDLE, then a read returning 01, 02, 03, 04: stray byte dropped; rdata = 32'h04030201.
- reset asserted during DATA after 2 bytes: all outputs at reset values next cycle and no rsp_valid; the next write emits the full 5-byte frame.
